// File: rtl/sdram_responder_model.sv
// Device-side model of a 16-bit SDR SDRAM. It decodes controller commands,
// runs the power-up init sequence and tracks which banks are open. Data is
// stored in a reduced array and read data comes back at the CAS latency.
// Protocol violations raise a sticky error flag and keep the first error code.
//
// Ports:
//   clk_clk        system clock, all sampling on the rising edge
//   reset_reset_n  asynchronous active-low reset
//   sdram_addr     row / column+A10 / mode word, depending on the command
//   sdram_ba       bank select
//   sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  command bits
//   sdram_cke      clock enable; when low, everything freezes
//   sdram_dqm      byte mask: [1]=dq[15:8], [0]=dq[7:0]
//   sdram_dq       bidirectional data bus
//   init_done      init sequence complete
//   err_flag       sticky protocol-violation flag
//   err_code       code of the first violation
//   refresh_count  number of AUTO REFRESH commands accepted (wraps)
module sdram_responder_model #(
  parameter int MEM_ROW_BITS = 4,
  parameter int MEM_COL_BITS = 6,
  parameter int DEFAULT_CL   = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        sdram_cke,
  input  logic [1:0]  sdram_dqm,
  inout  wire  [15:0] sdram_dq,
  output logic        init_done,
  output logic        err_flag,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_count
);

  localparam int ADDR_BITS = 2 + MEM_ROW_BITS + MEM_COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    ST_WAIT_PRE,
    ST_WAIT_REF1,
    ST_WAIT_REF2,
    ST_WAIT_MRS,
    ST_READY
  } init_state_t;

  init_state_t             state_reg;
  logic [3:0]              bank_active_reg;
  logic [MEM_ROW_BITS-1:0] open_row_reg [4];
  logic                    cl3_reg;
  logic                    init_done_reg;
  logic                    err_flag_reg;
  logic [2:0]              err_code_reg;
  logic [15:0]             refresh_count_reg;

  // Read path: capture stage (array read in flight), then a two-slot delay line.
  logic                    cap_valid_reg;
  logic                    cap_cl3_reg;
  logic [1:0]              pipe_valid_reg;
  logic [15:0]             pipe_data_reg [2];
  logic                    dq_oe_reg;
  logic [15:0]             dq_out_reg;

  // Command decode
  logic [3:0] cmd;
  logic is_nop, is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
  logic mode_ok;

  assign cmd    = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  // BURST TERM (0110) is treated as a NOP
  assign is_nop = sdram_cs_n || (cmd == 4'b0111) || (cmd == 4'b0110);
  assign is_act = (cmd == 4'b0011);
  assign is_rd  = (cmd == 4'b0101);
  assign is_wr  = (cmd == 4'b0100);
  assign is_pre = (cmd == 4'b0010);
  assign is_ref = (cmd == 4'b0001);
  assign is_mrs = (cmd == 4'b0000);

  // Only burst length 1 with CL 2 or 3 is supported
  assign mode_ok = (sdram_addr[2:0] == 3'b000) &&
                   ((sdram_addr[6:4] == 3'b010) || (sdram_addr[6:4] == 3'b011));

  // Upper row/column bits alias by design; fold them into one ignored net
  logic unused_addr;
  assign unused_addr = ^sdram_addr;

  logic       do_act, do_rd, do_wr, do_pre, do_ref, do_mrs;
  logic [2:0] err_now;

  always_comb begin
    do_act  = 1'b0;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    do_pre  = 1'b0;
    do_ref  = 1'b0;
    do_mrs  = 1'b0;
    err_now = 3'd0;
    if (state_reg != ST_READY) begin
      // During init only the next expected command (or a NOP) is legal
      case (state_reg)
        ST_WAIT_PRE: begin
          if (is_pre && sdram_addr[10]) do_pre = 1'b1;
          else if (!is_nop)             err_now = 3'd1;
        end
        ST_WAIT_REF1, ST_WAIT_REF2: begin
          if (is_ref)       do_ref = 1'b1;
          else if (!is_nop) err_now = 3'd1;
        end
        ST_WAIT_MRS: begin
          if (is_mrs) begin
            if (mode_ok) do_mrs = 1'b1;
            else         err_now = 3'd2;
          end else if (!is_nop) begin
            err_now = 3'd1;
          end
        end
        default: ;
      endcase
    end else begin
      if (is_act) begin
        if (bank_active_reg[sdram_ba]) err_now = 3'd4;
        else                           do_act = 1'b1;
      end
      if (is_rd || is_wr) begin
        if (!bank_active_reg[sdram_ba]) err_now = 3'd3;
        else begin
          do_rd = is_rd;
          do_wr = is_wr;
        end
      end
      if (is_pre) do_pre = 1'b1;
      if (is_ref) begin
        do_ref = 1'b1;
        if (|bank_active_reg) err_now = 3'd5;
      end
      if (is_mrs) begin
        if (mode_ok) do_mrs = 1'b1;
        else         err_now = 3'd2;
      end
      // A write landing on the edge where read data starts collides on the bus
      if (do_wr && pipe_valid_reg[0]) err_now = 3'd6;
    end
  end

  logic [ADDR_BITS-1:0] mem_addr;
  assign mem_addr = {sdram_ba, open_row_reg[sdram_ba], sdram_addr[MEM_COL_BITS-1:0]};

  // Storage split into byte lanes so each dqm bit is a plain write enable
  logic [7:0]  rd_lane [2];
  logic [15:0] rd_word;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];
    logic [7:0] rd_lane_reg;

    always_ff @(posedge clk_clk) begin
      if (sdram_cke) begin
        if (do_wr && !sdram_dqm[gi]) mem_lane[mem_addr] <= sdram_dq[gi*8 +: 8];
        if (do_rd)                   rd_lane_reg        <= mem_lane[mem_addr];
      end
    end

    assign rd_lane[gi] = rd_lane_reg;
  end

  assign rd_word = {rd_lane[1], rd_lane[0]};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg         <= ST_WAIT_PRE;
      bank_active_reg   <= '0;
      for (int b = 0; b < 4; b++) open_row_reg[b] <= '0;
      cl3_reg           <= (DEFAULT_CL == 3);
      init_done_reg     <= 1'b0;
      err_flag_reg      <= 1'b0;
      err_code_reg      <= 3'd0;
      refresh_count_reg <= 16'd0;
      cap_valid_reg     <= 1'b0;
      cap_cl3_reg       <= 1'b0;
      pipe_valid_reg    <= 2'b00;
      pipe_data_reg[0]  <= 16'd0;
      pipe_data_reg[1]  <= 16'd0;
      dq_oe_reg         <= 1'b0;
      dq_out_reg        <= 16'd0;
    end else if (sdram_cke) begin
      case (state_reg)
        ST_WAIT_PRE:  if (do_pre) state_reg <= ST_WAIT_REF1;
        ST_WAIT_REF1: if (do_ref) state_reg <= ST_WAIT_REF2;
        ST_WAIT_REF2: if (do_ref) state_reg <= ST_WAIT_MRS;
        ST_WAIT_MRS: begin
          if (do_mrs) begin
            state_reg     <= ST_READY;
            init_done_reg <= 1'b1;
          end
        end
        default: ;
      endcase

      if (do_act) begin
        bank_active_reg[sdram_ba] <= 1'b1;
        open_row_reg[sdram_ba]    <= sdram_addr[MEM_ROW_BITS-1:0];
      end
      // Auto-precharge: the access uses the open row, then the bank closes
      if ((do_rd || do_wr) && sdram_addr[10]) bank_active_reg[sdram_ba] <= 1'b0;
      if (do_pre) begin
        if (sdram_addr[10]) bank_active_reg           <= '0;
        else                bank_active_reg[sdram_ba] <= 1'b0;
      end

      if (do_ref) refresh_count_reg <= refresh_count_reg + 16'd1;
      if (do_mrs) cl3_reg <= sdram_addr[4];

      if ((err_now != 3'd0) && !err_flag_reg) begin
        err_flag_reg <= 1'b1;
        err_code_reg <= err_now;
      end

      // A fully masked read occupies no pipeline slot and never drives
      cap_valid_reg <= do_rd && (sdram_dqm != 2'b11);
      cap_cl3_reg   <= cl3_reg;

      // Captured word enters slot 1 (CL3) or slot 0 (CL2); slot 0 feeds dq
      pipe_valid_reg[0] <= pipe_valid_reg[1];
      pipe_data_reg[0]  <= pipe_data_reg[1];
      pipe_valid_reg[1] <= 1'b0;
      if (cap_valid_reg) begin
        if (cap_cl3_reg) begin
          pipe_valid_reg[1] <= 1'b1;
          pipe_data_reg[1]  <= rd_word;
        end else begin
          pipe_valid_reg[0] <= 1'b1;
          pipe_data_reg[0]  <= rd_word;
        end
      end

      dq_oe_reg  <= pipe_valid_reg[0] && !do_wr;
      dq_out_reg <= pipe_data_reg[0];
    end
  end

  assign sdram_dq      = dq_oe_reg ? dq_out_reg : 16'hzzzz;
  assign init_done     = init_done_reg;
  assign err_flag      = err_flag_reg;
  assign err_code      = err_code_reg;
  assign refresh_count = refresh_count_reg;

endmodule
